// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery
// into a single-entry valid/ready output register.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVS_FACTOR);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVS_FACTOR / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVS_FACTOR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  if (OVS_FACTOR < 4 ||
      (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_ovs_bad
    $fatal(1, "uart_rx: OVS_FACTOR must be a power of 2, >= 4");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_bad
    $fatal(1, "uart_rx: PARITY must be 0, 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_dbits_bad
    $fatal(1, "uart_rx: DATA_BITS must be 5..9");
  end

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  rx_state_e            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 commit;
  logic                 free;

  assign commit = tick_16x && state == STOP &&
                  tick_cnt == T_END;
  assign free   = !rx_valid || rx_ready;

  // tick_cnt wraps naturally at OVS_FACTOR-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else if (tick_16x) begin
      tick_cnt <= tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick_cnt == T_MID) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            state    <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_cnt == T_END) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == B_LAST)
              state <= (PARITY != PAR_NONE) ?
                       uart_pkg::PARITY : STOP;
          end
        end
        uart_pkg::PARITY: begin
          if (tick_cnt == T_END) begin
            par_bad <= (PARITY == PAR_ODD) ?
                       ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick_cnt == T_END)
            state <= rx_s ? IDLE : BREAK_WAIT;
        end
        BREAK_WAIT: begin
          tick_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= commit && !free;
      if (commit && free) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        parity_err <= par_bad;
        frame_err  <= ~rx_s;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: 8N1 and 8E1 instances.
module tb_uart_rx;

  localparam int BITC = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  logic rdy = 1'b1;
  logic rdy_p = 1'b1;
  logic [1:0] tdiv = '0;
  logic tick;

  logic [7:0] d0, d1;
  logic v0, pe0, fe0, ov0;
  logic v1, pe1, fe1, ov1;

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick = (tdiv == 2'd3);

  uart_rx #(.DATA_BITS(8), .OVS_FACTOR(16), .PARITY(0)) dut (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick), .rx(rx),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
  );

  uart_rx #(.DATA_BITS(8), .OVS_FACTOR(16), .PARITY(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick), .rx(rx_p),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy_p),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    bit         p;
    logic [7:0] d;
    logic       pb;
    logic       stop;
    int         gap;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int ncmp = 0;
  int nfail = 0;
  int vcyc0 = 0;
  int ovr0 = 0;
  int hs1 = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin : mon
      exp_t e;
      if (v0) vcyc0++;
      if (ov0) ovr0++;
      if (v0 && rdy) begin
        if (q0.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_valid0: got data %0h expected none", d0);
        end else begin
          e = q0.pop_front();
          chk("data0", 32'(d0), 32'(e.d));
          chk("perr0", 32'(pe0), 32'(e.pe));
          chk("ferr0", 32'(fe0), 32'(e.fe));
        end
      end
      if (v1 && rdy_p) begin
        hs1++;
        if (q1.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_valid1: got data %0h expected none", d1);
        end else begin
          e = q1.pop_front();
          chk("data1", 32'(d1), 32'(e.d));
          chk("perr1", 32'(pe1), 32'(e.pe));
          chk("ferr1", 32'(fe1), 32'(e.fe));
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input bit p, input logic v);
    if (p) rx_p = v;
    else rx = v;
    wclk(BITC);
  endtask

  task automatic send(input bit p, input logic [7:0] d,
                      input logic pb, input logic stop);
    drive_bit(p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
    if (p) drive_bit(p, pb);
    drive_bit(p, stop);
  endtask

  task automatic drain(input string nm);
    wclk(2 * BITC);
    chk(nm, 32'(q0.size() + q1.size()), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[6];
    logic [7:0] c3;
    int snap;
    vt[0] = '{0, 8'hA5, 0, 1, 2, 8'hA5, 0, 0};
    vt[1] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0};
    vt[2] = '{0, 8'hFF, 0, 1, 0, 8'hFF, 0, 0};
    vt[3] = '{0, 8'h3C, 0, 1, 2, 8'h3C, 0, 0};
    vt[4] = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0};
    vt[5] = '{1, 8'h07, 0, 1, 2, 8'h07, 1, 0};

    wclk(3);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_perr", 32'(pe0), 0);
    chk("rst_ferr", 32'(fe0), 0);
    chk("rst_overrun", 32'(ov0), 0);
    reset_n = 1'b1;
    wclk(20);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].p) q1.push_back('{vt[i].ed, vt[i].epe, vt[i].efe});
      else q0.push_back('{vt[i].ed, vt[i].epe, vt[i].efe});
      send(vt[i].p, vt[i].d, vt[i].pb, vt[i].stop);
      for (int g = 0; g < vt[i].gap; g++) drive_bit(vt[i].p, 1'b1);
      if (i == 0) chk("valid_cycles_basic", 32'(vcyc0), 1);
    end
    drain("drain_table");
    chk("valid_cycles_b2b", 32'(vcyc0), 4);
    chk("handshakes_parity", 32'(hs1), 2);
    chk("overrun_none", 32'(ovr0), 0);

    q0.push_back('{8'h55, 1'b0, 1'b1});
    send(0, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    chk("break_one_valid", 32'(vcyc0), 5);
    rx = 1'b1;
    drain("drain_break");
    chk("break_no_retrigger", 32'(vcyc0), 5);

    rdy = 1'b0;
    q0.push_back('{8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    wclk(BITC);
    chk("ovr_hold_data", 32'(d0), 32'h11);
    chk("ovr_hold_valid", 32'(v0), 1);
    chk("ovr_pulse", 32'(ovr0), 1);
    rdy = 1'b1;
    wclk(4);
    snap = vcyc0;
    rx = 1'b0;
    wclk(12);
    rx = 1'b1;
    wclk(3 * BITC);
    chk("glitch_no_valid", 32'(vcyc0), 32'(snap));
    drain("drain_overrun");

    c3 = 8'hC3;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, c3[i]);
    rx = c3[4];
    wclk(BITC / 2);
    reset_n = 1'b0;
    rx = 1'b1;
    wclk(2);
    chk("rst_mid_valid", 32'(v0), 0);
    chk("rst_mid_data", 32'(d0), 0);
    wclk(4);
    reset_n = 1'b1;
    wclk(BITC);
    snap = vcyc0;
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    send(0, 8'h5A, 1'b0, 1'b1);
    drain("drain_reset");
    chk("rst_one_valid", 32'(vcyc0), 32'(snap + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
